// File: rtl/issue_stage.sv
// issue_stage: one-entry issue buffer with a RAW/WAW register scoreboard and ALU/MEM dispatch.
// Optional feature macro ISSUE_WB_BYPASS_EN: mask the register retiring this cycle out of the hazard check.
`default_nettype none

module issue_stage #(
  parameter int NREGS = 32,
  parameter int REGW  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_iss_valid,
  input  logic [17:0]       id_iss_ctrl,
  input  logic [31:0]       id_iss_imedext,
  input  logic [REGW-1:0]   id_iss_regdest,
  input  logic [REGW-1:0]   id_iss_addra,
  input  logic [REGW-1:0]   id_iss_addrb,
  output logic              iss_id_stall,
  input  logic              ex_iss_alu_ready,
  input  logic              ex_iss_mem_ready,
  output logic              iss_ex_alu_valid,
  output logic              iss_ex_mem_valid,
  output logic [17:0]       iss_ex_ctrl,
  output logic [31:0]       iss_ex_imedext,
  output logic [REGW-1:0]   iss_ex_regdest,
  output logic [REGW-1:0]   iss_ex_addra,
  output logic [REGW-1:0]   iss_ex_addrb,
  input  logic              wb_iss_writereg,
  input  logic [REGW-1:0]   wb_iss_regdest,
  output logic [NREGS-1:0]  iss_hd_busy
);

  localparam int CTRL_SELIMREGB = 16;
  localparam int CTRL_READMEM   = 9;
  localparam int CTRL_WRITEMEM  = 8;
  localparam int CTRL_WRITEREG  = 6;

  logic              buf_valid_q;
  logic [17:0]       buf_ctrl_q;
  logic [31:0]       buf_imm_q;
  logic [REGW-1:0]   buf_rd_q;
  logic [REGW-1:0]   buf_ra_q;
  logic [REGW-1:0]   buf_rb_q;

  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [NREGS-1:0]  busy_chk;
  logic [NREGS-1:0]  wb_clr_mask;

  logic              alu_valid_q;
  logic              mem_valid_q;
  logic [17:0]       ex_ctrl_q;
  logic [31:0]       ex_imm_q;
  logic [REGW-1:0]   ex_rd_q;
  logic [REGW-1:0]   ex_ra_q;
  logic [REGW-1:0]   ex_rb_q;

  logic is_mem;
  logic need_a;
  logic need_b;
  logic dest_wr;
  logic raw;
  logic waw;
  logic unit_ready;
  logic dispatch;
  logic load;

  always_comb begin
    wb_clr_mask = '0;
    if (wb_iss_writereg && (wb_iss_regdest != '0)) begin
      wb_clr_mask[wb_iss_regdest] = 1'b1;
    end
  end

`ifdef ISSUE_WB_BYPASS_EN
  // A register retiring this cycle is already free from the consumer's point of view.
  assign busy_chk = busy_q & ~wb_clr_mask;
`else
  assign busy_chk = busy_q;
`endif

  assign is_mem     = buf_ctrl_q[CTRL_READMEM] | buf_ctrl_q[CTRL_WRITEMEM];
  assign need_a     = (buf_ra_q != '0);
  // Stores read rt as data even when the immediate feeds the ALU's B input.
  assign need_b     = (buf_rb_q != '0) &&
                      (!buf_ctrl_q[CTRL_SELIMREGB] || buf_ctrl_q[CTRL_WRITEMEM]);
  assign dest_wr    = buf_ctrl_q[CTRL_WRITEREG] && (buf_rd_q != '0);
  assign raw        = (need_a && busy_chk[buf_ra_q]) || (need_b && busy_chk[buf_rb_q]);
  assign waw        = dest_wr && busy_chk[buf_rd_q];
  assign unit_ready = is_mem ? ex_iss_mem_ready : ex_iss_alu_ready;
  assign dispatch   = buf_valid_q && !raw && !waw && unit_ready;
  assign load       = !buf_valid_q || dispatch;

  assign iss_id_stall = buf_valid_q && !dispatch;

  // Clear first, then set, so a dispatch claiming a register beats a same-edge retire.
  always_comb begin
    busy_d = busy_q & ~wb_clr_mask;
    if (dispatch && dest_wr) begin
      busy_d[buf_rd_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_ctrl_q  <= '0;
      buf_imm_q   <= '0;
      buf_rd_q    <= '0;
      buf_ra_q    <= '0;
      buf_rb_q    <= '0;
      busy_q      <= '0;
    end else begin
      busy_q <= busy_d;
      if (load) begin
        buf_valid_q <= id_iss_valid;
        buf_ctrl_q  <= id_iss_ctrl;
        buf_imm_q   <= id_iss_imedext;
        buf_rd_q    <= id_iss_regdest;
        buf_ra_q    <= id_iss_addra;
        buf_rb_q    <= id_iss_addrb;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_valid_q <= 1'b0;
      mem_valid_q <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_imm_q    <= '0;
      ex_rd_q     <= '0;
      ex_ra_q     <= '0;
      ex_rb_q     <= '0;
    end else begin
      alu_valid_q <= dispatch && !is_mem;
      mem_valid_q <= dispatch && is_mem;
      if (dispatch) begin
        ex_ctrl_q <= buf_ctrl_q;
        ex_imm_q  <= buf_imm_q;
        ex_rd_q   <= buf_rd_q;
        ex_ra_q   <= buf_ra_q;
        ex_rb_q   <= buf_rb_q;
      end
    end
  end

  assign iss_ex_alu_valid = alu_valid_q;
  assign iss_ex_mem_valid = mem_valid_q;
  assign iss_ex_ctrl      = ex_ctrl_q;
  assign iss_ex_imedext   = ex_imm_q;
  assign iss_ex_regdest   = ex_rd_q;
  assign iss_ex_addra     = ex_ra_q;
  assign iss_ex_addrb     = ex_rb_q;
  assign iss_hd_busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_stage.sv
// tb_issue_stage: directed scenarios plus randomized traffic against a scoreboard-level reference model.
`default_nettype none

module tb_issue_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        id_iss_valid = 1'b0;
  logic [17:0] id_iss_ctrl = '0;
  logic [31:0] id_iss_imedext = '0;
  logic [4:0]  id_iss_regdest = '0;
  logic [4:0]  id_iss_addra = '0;
  logic [4:0]  id_iss_addrb = '0;
  logic        iss_id_stall;
  logic        ex_iss_alu_ready = 1'b0;
  logic        ex_iss_mem_ready = 1'b0;
  logic        iss_ex_alu_valid;
  logic        iss_ex_mem_valid;
  logic [17:0] iss_ex_ctrl;
  logic [31:0] iss_ex_imedext;
  logic [4:0]  iss_ex_regdest;
  logic [4:0]  iss_ex_addra;
  logic [4:0]  iss_ex_addrb;
  logic        wb_iss_writereg = 1'b0;
  logic [4:0]  wb_iss_regdest = '0;
  logic [31:0] iss_hd_busy;

  int n_checks = 0;
  int n_fail   = 0;

  issue_stage #(.NREGS(32), .REGW(5)) dut (
    .clock(clock), .reset(reset),
    .id_iss_valid(id_iss_valid), .id_iss_ctrl(id_iss_ctrl), .id_iss_imedext(id_iss_imedext),
    .id_iss_regdest(id_iss_regdest), .id_iss_addra(id_iss_addra), .id_iss_addrb(id_iss_addrb),
    .iss_id_stall(iss_id_stall),
    .ex_iss_alu_ready(ex_iss_alu_ready), .ex_iss_mem_ready(ex_iss_mem_ready),
    .iss_ex_alu_valid(iss_ex_alu_valid), .iss_ex_mem_valid(iss_ex_mem_valid),
    .iss_ex_ctrl(iss_ex_ctrl), .iss_ex_imedext(iss_ex_imedext), .iss_ex_regdest(iss_ex_regdest),
    .iss_ex_addra(iss_ex_addra), .iss_ex_addrb(iss_ex_addrb),
    .wb_iss_writereg(wb_iss_writereg), .wb_iss_regdest(wb_iss_regdest),
    .iss_hd_busy(iss_hd_busy)
  );

  always #5 clock = ~clock;

  // Reference model: the waiting instruction, the set of in-flight destinations, and expected outputs.
  bit        mv;
  bit [17:0] mc;
  bit [31:0] mi;
  bit [4:0]  mrd, mra, mrb;
  bit [31:0] pending;
  bit        e_alu, e_mem;
  bit [17:0] e_ctrl;
  bit [31:0] e_imm;
  bit [4:0]  e_rd, e_ra, e_rb;
  bit        p_disp, p_stall;

  task automatic m_clear();
    mv = 0; mc = 0; mi = 0; mrd = 0; mra = 0; mrb = 0; pending = 0;
    e_alu = 0; e_mem = 0; e_ctrl = 0; e_imm = 0; e_rd = 0; e_ra = 0; e_rb = 0;
  endtask

  function automatic bit [17:0] mk_ctrl(bit rdm, bit wrm, bit wreg, bit selimm);
    bit [17:0] c = 18'h0;
    c[16] = selimm; c[9] = rdm; c[8] = wrm; c[6] = wreg;
    c[15:13] = 3'b101;
    return c;
  endfunction

  function automatic void predict();
    bit [31:0] in_flight = pending;
    bit        blocked = 0;
    bit        to_mem;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_iss_writereg && wb_iss_regdest != 0) in_flight[wb_iss_regdest] = 1'b0;
`endif
    if (mra != 0 && in_flight[mra]) blocked = 1;
    if ((!mc[16] || mc[8]) && mrb != 0 && in_flight[mrb]) blocked = 1;
    if (mc[6] && mrd != 0 && in_flight[mrd]) blocked = 1;
    to_mem  = mc[9] | mc[8];
    p_disp  = mv && !blocked && (to_mem ? ex_iss_mem_ready : ex_iss_alu_ready);
    p_stall = mv && !p_disp;
  endfunction

  task automatic tick();
    bit        iv = id_iss_valid;
    bit [17:0] ic = id_iss_ctrl;
    bit [31:0] ii = id_iss_imedext;
    bit [4:0]  ird = id_iss_regdest, ira = id_iss_addra, irb = id_iss_addrb;
    bit        we = wb_iss_writereg;
    bit [4:0]  wrd = wb_iss_regdest;
    predict();
    @(posedge clock);
    e_alu = p_disp && !(mc[9] | mc[8]);
    e_mem = p_disp &&  (mc[9] | mc[8]);
    if (p_disp) begin
      e_ctrl = mc; e_imm = mi; e_rd = mrd; e_ra = mra; e_rb = mrb;
    end
    if (we && wrd != 0) pending[wrd] = 1'b0;
    if (p_disp && mc[6] && mrd != 0) pending[mrd] = 1'b1;
    if (!mv || p_disp) begin
      mv = iv; mc = ic; mi = ii; mrd = ird; mra = ira; mrb = irb;
    end
    #1;
  endtask

  task automatic drive_insn(bit v, bit [17:0] c, bit [31:0] imm, bit [4:0] rd, bit [4:0] ra, bit [4:0] rb);
    id_iss_valid = v; id_iss_ctrl = c; id_iss_imedext = imm;
    id_iss_regdest = rd; id_iss_addra = ra; id_iss_addrb = rb;
    #1;
  endtask

  task automatic drive_wb(bit we, bit [4:0] rd);
    wb_iss_writereg = we; wb_iss_regdest = rd;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_insn(0, 0, 0, 0, 0, 0);
    drive_wb(0, 0);
    ex_iss_alu_ready = 1'b1; ex_iss_mem_ready = 1'b1;
    m_clear();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (iss_id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", iss_id_stall); end
    n_checks++; if ({iss_ex_alu_valid, iss_ex_mem_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids: got %b expected 00", {iss_ex_alu_valid, iss_ex_mem_valid}); end
    n_checks++; if ({iss_ex_ctrl, iss_ex_imedext, iss_ex_regdest, iss_ex_addra, iss_ex_addrb} !== '0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", {iss_ex_ctrl, iss_ex_imedext, iss_ex_regdest, iss_ex_addra, iss_ex_addrb}); end
    n_checks++; if (iss_hd_busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", iss_hd_busy); end
  endtask

  task automatic test_raw();
    do_reset();
    drive_insn(1, mk_ctrl(0, 0, 1, 0), 32'h11, 5'd3, 5'd1, 5'd2);
    tick();
    drive_insn(1, mk_ctrl(0, 0, 1, 0), 32'h22, 5'd4, 5'd3, 5'd0);
    n_checks++; if (iss_id_stall !== 1'b0) begin n_fail++; $display("FAIL raw_add_stall: got %b expected 0", iss_id_stall); end
    tick();
    n_checks++; if (iss_ex_alu_valid !== 1'b1 || iss_ex_regdest !== 5'd3) begin n_fail++; $display("FAIL raw_add_dispatch: got v=%b rd=%0d expected v=1 rd=3", iss_ex_alu_valid, iss_ex_regdest); end
    n_checks++; if (iss_hd_busy[3] !== 1'b1) begin n_fail++; $display("FAIL raw_busy3_set: got %b expected 1", iss_hd_busy[3]); end
    drive_insn(0, 0, 0, 0, 0, 0);
    repeat (2) begin
      n_checks++; if (iss_id_stall !== 1'b1) begin n_fail++; $display("FAIL raw_sub_stall: got %b expected 1", iss_id_stall); end
      tick();
      n_checks++; if (iss_ex_alu_valid !== 1'b0) begin n_fail++; $display("FAIL raw_sub_held: got %b expected 0", iss_ex_alu_valid); end
    end
    drive_wb(1, 5'd3);
`ifdef ISSUE_WB_BYPASS_EN
    n_checks++; if (iss_id_stall !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle_stall: got %b expected 0", iss_id_stall); end
    tick();
    drive_wb(0, 0);
    n_checks++; if (iss_ex_alu_valid !== 1'b1 || iss_ex_regdest !== 5'd4) begin n_fail++; $display("FAIL raw_sub_dispatch: got v=%b rd=%0d expected v=1 rd=4", iss_ex_alu_valid, iss_ex_regdest); end
`else
    n_checks++; if (iss_id_stall !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle_stall: got %b expected 1", iss_id_stall); end
    tick();
    drive_wb(0, 0);
    n_checks++; if (iss_ex_alu_valid !== 1'b0 || iss_hd_busy[3] !== 1'b0) begin n_fail++; $display("FAIL raw_after_wb: got v=%b busy3=%b expected v=0 busy3=0", iss_ex_alu_valid, iss_hd_busy[3]); end
    n_checks++; if (iss_id_stall !== 1'b0) begin n_fail++; $display("FAIL raw_release_stall: got %b expected 0", iss_id_stall); end
    tick();
    n_checks++; if (iss_ex_alu_valid !== 1'b1 || iss_ex_regdest !== 5'd4) begin n_fail++; $display("FAIL raw_sub_dispatch: got v=%b rd=%0d expected v=1 rd=4", iss_ex_alu_valid, iss_ex_regdest); end
`endif
    n_checks++; if (iss_hd_busy !== 32'h0000_0010) begin n_fail++; $display("FAIL raw_busy_end: got %h expected 00000010", iss_hd_busy); end
  endtask

  task automatic test_waw();
    do_reset();
    drive_insn(1, mk_ctrl(0, 0, 1, 0), 32'hA1, 5'd7, 5'd1, 5'd2);
    tick();
    drive_insn(1, mk_ctrl(0, 0, 1, 1), 32'hA2, 5'd7, 5'd0, 5'd0);
    tick();
    drive_insn(0, 0, 0, 0, 0, 0);
    repeat (2) begin
      n_checks++; if (iss_id_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b expected 1", iss_id_stall); end
      tick();
    end
    drive_wb(1, 5'd7);
`ifdef ISSUE_WB_BYPASS_EN
    tick();
`else
    tick();
    drive_wb(0, 0);
    n_checks++; if (iss_ex_alu_valid !== 1'b0 || iss_hd_busy[7] !== 1'b0) begin n_fail++; $display("FAIL waw_after_wb: got v=%b busy7=%b expected v=0 busy7=0", iss_ex_alu_valid, iss_hd_busy[7]); end
    tick();
`endif
    drive_wb(0, 0);
    n_checks++; if (iss_ex_alu_valid !== 1'b1 || iss_ex_imedext !== 32'hA2) begin n_fail++; $display("FAIL waw_dispatch: got v=%b imm=%h expected v=1 imm=a2", iss_ex_alu_valid, iss_ex_imedext); end
    n_checks++; if (iss_hd_busy[7] !== 1'b1) begin n_fail++; $display("FAIL waw_busy7: got %b expected 1", iss_hd_busy[7]); end
  endtask

  task automatic test_unit_routing();
    bit [17:0] lw = mk_ctrl(1, 0, 1, 1);
    do_reset();
    ex_iss_mem_ready = 1'b0;
    drive_insn(1, lw, 32'h40, 5'd2, 5'd1, 5'd0);
    tick();
    drive_insn(0, 0, 0, 0, 0, 0);
    repeat (3) begin
      n_checks++; if (iss_id_stall !== 1'b1) begin n_fail++; $display("FAIL route_stall: got %b expected 1", iss_id_stall); end
      tick();
      n_checks++; if ({iss_ex_alu_valid, iss_ex_mem_valid} !== 2'b00) begin n_fail++; $display("FAIL route_held: got %b expected 00", {iss_ex_alu_valid, iss_ex_mem_valid}); end
    end
    ex_iss_mem_ready = 1'b1; #1;
    n_checks++; if (iss_id_stall !== 1'b0) begin n_fail++; $display("FAIL route_release: got %b expected 0", iss_id_stall); end
    tick();
    n_checks++; if ({iss_ex_alu_valid, iss_ex_mem_valid} !== 2'b01 || iss_ex_ctrl !== lw || iss_ex_regdest !== 5'd2) begin n_fail++; $display("FAIL route_mem_pulse: got av/mv=%b ctrl=%h rd=%0d expected 01 ctrl=%h rd=2", {iss_ex_alu_valid, iss_ex_mem_valid}, iss_ex_ctrl, iss_ex_regdest, lw); end
    tick();
    n_checks++; if ({iss_ex_alu_valid, iss_ex_mem_valid} !== 2'b00 || iss_ex_regdest !== 5'd2) begin n_fail++; $display("FAIL route_one_pulse: got %b rd=%0d expected 00 rd=2", {iss_ex_alu_valid, iss_ex_mem_valid}, iss_ex_regdest); end
  endtask

  task automatic test_r0();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_insn(1, mk_ctrl(0, 0, 1, i[0]), 32'(i), 5'd0, 5'd0, 5'd0);
      else       drive_insn(0, 0, 0, 0, 0, 0);
      n_checks++; if (iss_id_stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall[%0d]: got %b expected 0", i, iss_id_stall); end
      tick();
      if (i >= 1) begin
        n_checks++; if (iss_ex_alu_valid !== 1'b1 || iss_ex_imedext !== 32'(i - 1)) begin n_fail++; $display("FAIL r0_dispatch[%0d]: got v=%b imm=%h expected v=1 imm=%h", i, iss_ex_alu_valid, iss_ex_imedext, i - 1); end
      end
    end
    n_checks++; if (iss_hd_busy !== 32'h0) begin n_fail++; $display("FAIL r0_busy: got %h expected 0", iss_hd_busy); end
  endtask

  task automatic test_collision();
    do_reset();
    drive_insn(1, mk_ctrl(0, 0, 1, 1), 32'h99, 5'd9, 5'd0, 5'd0);
    tick();
    drive_insn(0, 0, 0, 0, 0, 0);
    drive_wb(1, 5'd9);
    tick();
    drive_wb(0, 0);
    n_checks++; if (iss_ex_alu_valid !== 1'b1 || iss_hd_busy[9] !== 1'b1) begin n_fail++; $display("FAIL collision: got v=%b busy9=%b expected v=1 busy9=1", iss_ex_alu_valid, iss_hd_busy[9]); end
  endtask

  task automatic test_reset_midstall();
    do_reset();
    drive_insn(1, mk_ctrl(0, 0, 1, 1), 32'h55, 5'd5, 5'd0, 5'd0);
    tick();
    drive_insn(1, mk_ctrl(0, 0, 1, 1), 32'h66, 5'd6, 5'd5, 5'd0);
    tick();
    drive_insn(0, 0, 0, 0, 0, 0);
    n_checks++; if (iss_id_stall !== 1'b1 || iss_hd_busy[5] !== 1'b1) begin n_fail++; $display("FAIL midstall_setup: got stall=%b busy5=%b expected 1/1", iss_id_stall, iss_hd_busy[5]); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (iss_id_stall !== 1'b0 || iss_hd_busy !== 32'h0) begin n_fail++; $display("FAIL midstall_reset: got stall=%b busy=%h expected 0/0", iss_id_stall, iss_hd_busy); end
    n_checks++; if ({iss_ex_alu_valid, iss_ex_mem_valid, iss_ex_ctrl, iss_ex_imedext, iss_ex_regdest, iss_ex_addra, iss_ex_addrb} !== '0) begin n_fail++; $display("FAIL midstall_outputs: got nonzero outputs expected 0"); end
    m_clear();
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ex_iss_alu_ready = ($urandom % 4) != 0;
      ex_iss_mem_ready = ($urandom % 4) != 0;
      drive_wb(($urandom % 3) == 0, 5'($urandom % 8));
      drive_insn(($urandom % 4) != 0, 18'($urandom), $urandom,
                 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8));
      predict();
      n_checks++; if (iss_id_stall !== p_stall) begin n_fail++; $display("FAIL rand_stall@%0d: got %b expected %b", cyc, iss_id_stall, p_stall); end
      tick();
      n_checks++; if ({iss_ex_alu_valid, iss_ex_mem_valid} !== {e_alu, e_mem}) begin n_fail++; $display("FAIL rand_valids@%0d: got %b expected %b", cyc, {iss_ex_alu_valid, iss_ex_mem_valid}, {e_alu, e_mem}); end
      n_checks++; if ({iss_ex_ctrl, iss_ex_imedext, iss_ex_regdest, iss_ex_addra, iss_ex_addrb} !== {e_ctrl, e_imm, e_rd, e_ra, e_rb}) begin n_fail++; $display("FAIL rand_fields@%0d: got %h expected %h", cyc, {iss_ex_ctrl, iss_ex_imedext, iss_ex_regdest, iss_ex_addra, iss_ex_addrb}, {e_ctrl, e_imm, e_rd, e_ra, e_rb}); end
      n_checks++; if (iss_hd_busy !== pending) begin n_fail++; $display("FAIL rand_busy@%0d: got %h expected %h", cyc, iss_hd_busy, pending); end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_unit_routing();
    test_r0();
    test_collision();
    test_reset_midstall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Sits directly downstream of decode.
- Captures each decoded instruction into a one-entry issue buffer and checks a 32-entry register scoreboard for RAW and WAW hazards.
- Picks the target functional unit (ALU/shift or MEM) and dispatches with a valid/ready handshake.
- Drives the decode stall line (decode's id_stall) whenever the buffered instruction cannot leave; writeback clears scoreboard entries.

Parameters:
NREGS, 32, architectural register count; scoreboard depth.
REGW, 5, register address width.

Ports:
clock  in  1  single clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
id_iss_valid  in  1  decode output holds a real instruction; low for bubbles and discarded slots.
id_iss_ctrl  in  18  packed decode control {selalushift, selimregb, aluop[2:0], unsig, shiftop[1:0], readmem, writemem, selwsource, writereg, writeov, selregdest, op-unused pad[3:0]}.
id_iss_imedext  in  32  sign-extended immediate.
id_iss_regdest  in  5  destination register.
id_iss_addra  in  5  rs address.
id_iss_addrb  in  5  rt address.
iss_id_stall  out  1  decode must hold its outputs; combinational.
ex_iss_alu_ready  in  1  ALU/shift unit accepts this cycle.
ex_iss_mem_ready  in  1  memory unit accepts this cycle.
iss_ex_alu_valid  out  1  registered dispatch strobe to ALU unit.
iss_ex_mem_valid  out  1  registered dispatch strobe to MEM unit.
iss_ex_ctrl  out  18  registered copy of dispatched control.
iss_ex_imedext  out  32  registered immediate.
iss_ex_regdest  out  5  registered destination.
iss_ex_addra  out  5  registered rs address.
iss_ex_addrb  out  5  registered rt address.
wb_iss_writereg  in  1  writeback retires a register write this cycle.
wb_iss_regdest  in  5  register being retired.
iss_hd_busy  out  32  scoreboard busy vector, for decode's hazard detector.

Behaviour:
- Reset (reset low, async): buffer invalid, all scoreboard bits 0, every output register 0, iss_id_stall 0.
- Buffer load: on posedge, if buffer empty or dispatching, capture decode fields and valid=id_iss_valid; otherwise hold.
- Unit select: mem = readmem|writemem; otherwise ALU.
- Operand need:
  - A: needed when addra!=0.
  - B: needed when addrb!=0 and (selimregb==0 or writemem==1).
- Hazard:
  - RAW = (needA & busy[addra]) | (needB & busy[addrb]).
  - WAW = writereg & regdest!=0 & busy[regdest].
- Dispatch (combinational) = valid & !RAW & !WAW & selected unit ready.
- On a dispatch edge:
  - Selected iss_ex_*_valid is 1 for exactly one cycle; fields are copied.
  - busy[regdest] is set if writereg & regdest!=0.
- Without dispatch: both valid strobes are 0 and fields hold their last value.
- iss_id_stall = valid & !dispatch.
- Latency: decode edge N → buffer edge N+1 → dispatch edge N+2 best case; throughput one instruction per cycle.
- Scoreboard clear: wb_iss_writereg & wb_iss_regdest!=0 clears that bit at posedge.
- Simultaneous set and clear of the same register: set wins.
- Register 0: never set busy, never a hazard.
- Ready low: stall holds indefinitely and the buffer is unchanged; no dispatch to a unit whose ready is low.
- Invalid entry: never dispatches, never stalls, never touches the scoreboard.
- iss_hd_busy reflects registered scoreboard state.

Optional Feature:
- ISSUE_WB_BYPASS_EN defined: the hazard check uses busy with the same-cycle writeback bit masked, so a RAW/WAW on a register retiring this cycle dispatches in the same cycle and saves one stall cycle.
- Undefined: hazard check uses registered busy only; the instruction dispatches the cycle after the clear.

Test Plan:
- Reset mid-stall: busy[5]=1 with a stalled entry, pull reset low → all outputs 0, busy=0, iss_id_stall=0 immediately.
- RAW: issue add r3←r1,r2, then sub r4←r3,r0 with no writeback → sub stalls; wb r3 at cycle T → sub dispatches at T+1 (T with ISSUE_WB_BYPASS_EN).
- WAW: two back-to-back writes to r7 → second stalls until wb r7 retires.
- Unit routing: lw r2 with mem_ready=0 for 3 cycles → iss_id_stall=1 for 3 cycles, then iss_ex_mem_valid pulses once, alu_valid stays 0.
- r0 handling: writes and reads of r0 back-to-back → no stall, busy[0] stays 0.
- Set/clear collision: dispatch write r9 while wb retires r9 the same edge → busy[9]=1 afterwards.
